// File: rtl/ptr_sched.sv
// Pointer-struct scheduler for the polyphase upsampler controller: per request it returns the
// newest ring address, coefficient base, tap count and phase, gating validity until warmed up.
module ptr_sched #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 9,
  parameter int unsigned PW = 4,
  parameter int unsigned TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] cfg_l,
  input  logic [TW-1:0] cfg_taps,
  input  logic          new_in,
  input  logic          ptrs_req,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] smp_addr,
  output logic [CW-1:0] coef_addr,
  output logic [TW-1:0] tap_cnt,
  output logic [PW-1:0] phase,
  output logic          req_complete,
  output logic          iw_valid,
  output logic          overrun
);

  typedef enum logic [1:0] {StIdle, StCalc, StWaitIn, StDone} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] l_q, phase_cnt_q, phase_cnt_d, phase_q;
  logic [TW-1:0] taps_q, fill_q, fill_d, tap_cnt_q;
  logic [1:0]    in_pend_q, in_pend_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q, smp_addr_q;
  logic [CW-1:0] coef_addr_q, coef_prod;
  logic          iw_valid_q;

  logic          latch_cfg, calc_exit, consume, sample_in;

  assign sample_in = en & new_in;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every transition is qualified by en.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        StIdle:   if (ptrs_req) state_d = StCalc;
        StCalc:   state_d = (phase_cnt_q == '0 && in_pend_q == 2'd0) ? StWaitIn : StDone;
        // A new_in arriving this cycle counts before the pending check.
        StWaitIn: if (in_pend_q != 2'd0 || new_in) state_d = StCalc;
        StDone:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    req_complete = 1'b0;
    latch_cfg    = 1'b0;
    calc_exit    = 1'b0;
    consume      = 1'b0;
    unique case (state_q)
      StIdle: latch_cfg = en & ptrs_req;
      StCalc: begin
        calc_exit = en & ~(phase_cnt_q == '0 && in_pend_q == 2'd0);
        consume   = calc_exit & (phase_cnt_q == '0);
      end
      StDone:   req_complete = 1'b1;
      default:  ;
    endcase
  end

  // Pending-sample counter with sticky overrun on saturation.
  always_comb begin
    in_pend_d = in_pend_q;
    overrun_d = overrun_q;
    if (sample_in && !consume) begin
      if (in_pend_q == 2'd3) overrun_d = 1'b1;
      else                   in_pend_d = in_pend_q + 2'd1;
    end else if (consume && !sample_in) begin
      in_pend_d = in_pend_q - 2'd1;
    end
  end

  always_comb begin
    fill_d = fill_q;
    if (consume && fill_q != {TW{1'b1}}) fill_d = fill_q + TW'(1);
  end

  // Phase steps only once the delay line is full; >= guards against L shrinking mid-cycle.
  always_comb begin
    phase_cnt_d = phase_cnt_q;
    if (en && state_q == StDone && iw_valid_q) begin
      phase_cnt_d = (phase_cnt_q >= l_q - PW'(1)) ? '0 : phase_cnt_q + PW'(1);
    end
  end

  assign coef_prod = CW'(phase_cnt_q) * CW'(taps_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_q         <= '0;
      taps_q      <= '0;
      phase_cnt_q <= '0;
      fill_q      <= '0;
      in_pend_q   <= '0;
      overrun_q   <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      smp_addr_q  <= '0;
      coef_addr_q <= '0;
      tap_cnt_q   <= '0;
      phase_q     <= '0;
      iw_valid_q  <= 1'b0;
    end else begin
      in_pend_q   <= in_pend_d;
      overrun_q   <= overrun_d;
      fill_q      <= fill_d;
      phase_cnt_q <= phase_cnt_d;
      if (sample_in) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (latch_cfg) begin
        l_q    <= (cfg_l == '0) ? PW'(1) : cfg_l;
        taps_q <= (cfg_taps == '0) ? TW'(1) : cfg_taps;
      end
      if (consume) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        smp_addr_q <= rd_ptr_q;
      end
      if (calc_exit) begin
        coef_addr_q <= coef_prod;
        tap_cnt_q   <= taps_q;
        phase_q     <= phase_cnt_q;
        iw_valid_q  <= (fill_d >= taps_q);
      end
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign smp_addr  = smp_addr_q;
  assign coef_addr = coef_addr_q;
  assign tap_cnt   = tap_cnt_q;
  assign phase     = phase_q;
  assign iw_valid  = iw_valid_q;
  assign overrun   = overrun_q;

endmodule
